// File: rtl/fetch_pkg.sv
// Purpose: shared widths, HALT opcode, fetch FSM states and first-HALT helper for the front end.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;
    localparam int         FETCH_W = 4;
    localparam int         INSTR_W = 16;
    localparam int         PC_W    = 16;
    localparam int         GRP_W   = FETCH_W * INSTR_W;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_t;

    // Slot 0 sits in the top 16 bits; the opcode is the top nibble of each slot.
    // Returns the lowest slot index below n holding HALT, or FETCH_W when there is none.
    function automatic logic [2:0] first_halt(input logic [GRP_W-1:0] instr_flat,
                                              input logic [2:0]       n);
        logic [2:0] idx;
        idx = 3'(FETCH_W);
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if ((3'(i) < n) && (instr_flat[(FETCH_W - i) * INSTR_W - 1 -: 4] == OP_HALT)) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Purpose: circular instruction/PC queue, up to 4 writes and 4 in-order reads per cycle, with flush.
// Latency: a write is visible at the read side the cycle after it is accepted (no bypass).
// Backpressure: writer must not exceed o_free; reads are clamped to the entries actually present.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic [2:0]              i_wr_cnt,
    input  logic [GRP_W-1:0]        i_wr_instr_flat,
    input  logic [GRP_W-1:0]        i_wr_pc_flat,
    input  logic [2:0]              i_rd_take,
    output logic [2:0]              o_rd_count,
    output logic [GRP_W-1:0]        o_rd_instr_flat,
    output logic [GRP_W-1:0]        o_rd_pc_flat,
    output logic [$clog2(DEPTH):0]  o_free
);
    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [AW:0]        r_head;
    logic [AW:0]        r_tail;
    logic [AW:0]        w_occ;
    logic [2:0]         w_take;
    logic [AW-1:0]      w_wr_idx [FETCH_W];
    logic [AW-1:0]      w_rd_idx [FETCH_W];

    // Extra pointer MSB distinguishes full from empty, so occupancy is a plain difference.
    assign w_occ      = r_tail - r_head;
    assign o_free     = (AW + 1)'(DEPTH) - w_occ;
    assign o_rd_count = (w_occ >= (AW + 1)'(FETCH_W)) ? 3'(FETCH_W) : w_occ[2:0];
    assign w_take     = (i_rd_take > o_rd_count) ? o_rd_count : i_rd_take;

    // Per-slot storage indices, wrapping naturally at DEPTH.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_wr_idx[i] = r_tail[AW-1:0] + AW'(i);
            w_rd_idx[i] = r_head[AW-1:0] + AW'(i);
        end
    end

    // Present the oldest entries; slots beyond the valid count read as zero.
    always_comb begin
        o_rd_instr_flat = '0;
        o_rd_pc_flat    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (3'(i) < o_rd_count) begin
                o_rd_instr_flat[GRP_W - 1 - INSTR_W * i -: INSTR_W] = r_instr_mem[w_rd_idx[i]];
                o_rd_pc_flat[GRP_W - 1 - PC_W * i -: PC_W]          = r_pc_mem[w_rd_idx[i]];
            end
        end
    end

    // Storage write; data needs no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (!i_flush && (3'(i) < i_wr_cnt)) begin
                r_instr_mem[w_wr_idx[i]] <= i_wr_instr_flat[GRP_W - 1 - INSTR_W * i -: INSTR_W];
                r_pc_mem[w_wr_idx[i]]    <= i_wr_pc_flat[GRP_W - 1 - PC_W * i -: PC_W];
            end
        end
    end

    // Pointer update; flush wins over this cycle's write and read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_tail <= r_tail + (AW + 1)'(i_wr_cnt);
            r_head <= r_head + (AW + 1)'(w_take);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: front-end PC sequencer feeding a combinational icache into a DEPTH-entry queue; HALT stops fetch.
// Latency: fetched group enqueued at the clock edge, presented to dispatch the next cycle; redirect takes effect next cycle.
// Backpressure: fetch width = min(4, free) from registered pointers; full queue holds the PC group.
// Optional statistics counters are built when FETCH_SEQ_STATS_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [63:0] pc_to_icache_flat,
    input  logic [63:0] instr_flat,
    output logic [2:0]  deq_count,
    output logic [63:0] deq_instr_flat,
    output logic [63:0] deq_pc_flat,
    input  logic [2:0]  deq_take,
    output logic [2:0]  num_fetch,
    output logic        halted
`ifdef FETCH_SEQ_STATS_EN
    ,
    output logic [31:0] stat_full_cycles,
    output logic [31:0] stat_redirects,
    output logic [31:0] stat_fetched
`endif
);
    localparam int AW = $clog2(DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  w_fetch_pc_nxt;
    logic [AW:0]      w_free;
    logic [2:0]       w_cap;
    logic [2:0]       w_halt_idx;
    logic             w_halt_hit;
    logic             w_run;
    logic [2:0]       w_n;
    logic [GRP_W-1:0] w_pc_group;

    // Four consecutive halfword PCs, 16-bit wrap.
    always_comb begin
        w_pc_group = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_pc_group[GRP_W - 1 - PC_W * i -: PC_W] = r_fetch_pc + PC_W'(2 * i);
        end
    end

    assign pc_to_icache_flat = w_pc_group;
    assign w_cap      = (w_free >= (AW + 1)'(FETCH_W)) ? 3'(FETCH_W) : w_free[2:0];
    assign w_halt_idx = first_halt(instr_flat, w_cap);
    assign w_halt_hit = (w_halt_idx != 3'(FETCH_W));
    // Redirect discards this cycle's group; reset forces a quiet interface.
    assign w_run      = rst_n && !redirect_valid && (r_state == FS_RUN);
    assign w_n        = w_run ? (w_halt_hit ? (w_halt_idx + 3'd1) : w_cap) : 3'd0;
    assign num_fetch  = w_n;
    assign halted     = (r_state == FS_HALTED);

    // FSM and fetch PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_RUN;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // Next state: redirect has top priority from any state; HALT stops fetch after it is enqueued.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect_valid) begin
            w_state_nxt    = FS_RUN;
            w_fetch_pc_nxt = redirect_pc;
        end else if (r_state == FS_RUN) begin
            w_fetch_pc_nxt = r_fetch_pc + PC_W'({w_n, 1'b0});
            if (w_halt_hit) begin
                w_state_nxt = FS_HALTED;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (redirect_valid),
        .i_wr_cnt        (w_n),
        .i_wr_instr_flat (instr_flat),
        .i_wr_pc_flat    (w_pc_group),
        .i_rd_take       (deq_take),
        .o_rd_count      (deq_count),
        .o_rd_instr_flat (deq_instr_flat),
        .o_rd_pc_flat    (deq_pc_flat),
        .o_free          (w_free)
    );

`ifdef FETCH_SEQ_STATS_EN
    logic [31:0] r_stat_full;
    logic [31:0] r_stat_redir;
    logic [31:0] r_stat_fetched;
    logic [32:0] w_fetched_sum;

    assign w_fetched_sum    = {1'b0, r_stat_fetched} + 33'(w_n);
    assign stat_full_cycles = r_stat_full;
    assign stat_redirects   = r_stat_redir;
    assign stat_fetched     = r_stat_fetched;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_full    <= '0;
            r_stat_redir   <= '0;
            r_stat_fetched <= '0;
        end else begin
            if (w_run && (w_n == 3'd0) && (r_stat_full != '1)) begin
                r_stat_full <= r_stat_full + 32'd1;
            end
            if (redirect_valid && (r_stat_redir != '1)) begin
                r_stat_redir <= r_stat_redir + 32'd1;
            end
            r_stat_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: directed self-checking bench for fetch_sequencer with a behavioural icache.
// Latency: inputs change at the falling edge, outputs are sampled 1 time unit later.
// Backpressure: dispatch consumption driven directly through deq_take.
module tb_fetch_sequencer;
    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [63:0] pc_to_icache_flat;
    logic [63:0] instr_flat;
    logic [2:0]  deq_count;
    logic [63:0] deq_instr_flat;
    logic [63:0] deq_pc_flat;
    logic [2:0]  deq_take;
    logic [2:0]  num_fetch;
    logic        halted;
`ifdef FETCH_SEQ_STATS_EN
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_redirects;
    logic [31:0] stat_fetched;
`endif

    logic        halt_en;
    logic [15:0] halt_pc;
    int          n_tests;
    int          n_fail;

    fetch_sequencer #(
        .DEPTH    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pc_to_icache_flat (pc_to_icache_flat),
        .instr_flat        (instr_flat),
        .deq_count         (deq_count),
        .deq_instr_flat    (deq_instr_flat),
        .deq_pc_flat       (deq_pc_flat),
        .deq_take          (deq_take),
        .num_fetch         (num_fetch),
        .halted            (halted)
`ifdef FETCH_SEQ_STATS_EN
        ,
        .stat_full_cycles  (stat_full_cycles),
        .stat_redirects    (stat_redirects),
        .stat_fetched      (stat_fetched)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Icache model: instruction = {opcode, pc[11:0]}, opcode HALT only at halt_pc when enabled.
    always_comb begin
        logic [15:0] pc;
        instr_flat = '0;
        for (int i = 0; i < 4; i++) begin
            pc = pc_to_icache_flat[63 - 16 * i -: 16];
            instr_flat[63 - 16 * i -: 16] = {((halt_en && (pc == halt_pc)) ? 4'hF : 4'h0), pc[11:0]};
        end
    end

    function automatic logic [63:0] grp(input logic [15:0] pc);
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] p3;
        p1 = pc + 16'd2;
        p2 = pc + 16'd4;
        p3 = pc + 16'd6;
        return {pc, p1, p2, p3};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; caller sets inputs, then waits #1 before checking.
    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        deq_take       = 3'd0;
        halt_en        = 1'b0;
        halt_pc        = 16'h0000;

        // Reset state
        fall(); fall(); #1;
        chk("rst_num_fetch", 64'(num_fetch), 64'd0);
        chk("rst_deq_count", 64'(deq_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc_group", pc_to_icache_flat, grp(16'h0000));

        // Fill from reset with no consumption
        fall(); rst_n = 1'b1; #1;
        chk("fill_c0_nf", 64'(num_fetch), 64'd4);
        chk("fill_c0_cnt", 64'(deq_count), 64'd0);
        fall(); #1;
        chk("fill_c1_nf", 64'(num_fetch), 64'd4);
        chk("fill_c1_cnt", 64'(deq_count), 64'd4);
        chk("fill_c1_pcgrp", pc_to_icache_flat, grp(16'd8));
        chk("fill_c1_deqpc", deq_pc_flat, grp(16'd0));
        fall(); #1;
        chk("fill_c2_nf", 64'(num_fetch), 64'd4);
        fall(); #1;
        chk("fill_c3_nf", 64'(num_fetch), 64'd4);
        chk("fill_c3_pcgrp", pc_to_icache_flat, grp(16'd24));
        fall(); #1;
        chk("full_nf", 64'(num_fetch), 64'd0);
        chk("full_pcgrp", pc_to_icache_flat, grp(16'd32));
        chk("full_cnt", 64'(deq_count), 64'd4);

        // Full queue, take 2 -> DEPTH-2 occupancy, then take 4 without same-cycle credit
        fall(); deq_take = 3'd2; #1;
        chk("full_hold_nf", 64'(num_fetch), 64'd0);
        chk("full_hold_pcgrp", pc_to_icache_flat, grp(16'd32));
        chk("full_deqpc", deq_pc_flat, grp(16'd0));
        chk("full_deqinstr", deq_instr_flat, 64'h0000_0002_0004_0006);
        fall(); deq_take = 3'd4; #1;
        chk("d14_nf", 64'(num_fetch), 64'd2);
        chk("d14_deqpc", deq_pc_flat, grp(16'd4));
        fall(); #1;
        chk("d12_nf", 64'(num_fetch), 64'd4);
        chk("d12_deqpc", deq_pc_flat, grp(16'd12));
        chk("d12_pcgrp", pc_to_icache_flat, grp(16'd36));

        // Steady state, take 4 every cycle; pointers wrap past 2*DEPTH enqueues
        for (int i = 0; i < 6; i++) begin
            fall(); #1;
            chk("steady_nf", 64'(num_fetch), 64'd4);
            chk("steady_deqpc", deq_pc_flat, grp(16'(20 + 8 * i)));
        end

        // HALT in slot 2 of the group at PC 8
        fall(); redirect_valid = 1'b1; redirect_pc = 16'h0008; deq_take = 3'd0;
        halt_en = 1'b1; halt_pc = 16'h000C; #1;
        chk("redir_run_nf", 64'(num_fetch), 64'd0);
        fall(); redirect_valid = 1'b0; #1;
        chk("halt_flush_cnt", 64'(deq_count), 64'd0);
        chk("halt_pcgrp", pc_to_icache_flat, grp(16'h0008));
        chk("halt_nf", 64'(num_fetch), 64'd3);
        chk("halt_pre_halted", 64'(halted), 64'd0);
        fall(); deq_take = 3'd2; #1;
        chk("halted_flag", 64'(halted), 64'd1);
        chk("halted_nf", 64'(num_fetch), 64'd0);
        chk("halted_cnt", 64'(deq_count), 64'd3);
        chk("halted_deqpc", deq_pc_flat, 64'h0008_000A_000C_0000);
        chk("halted_deqinstr", deq_instr_flat, 64'h0008_000A_F00C_0000);
        fall(); deq_take = 3'd4; #1;
        chk("clamp_cnt1", 64'(deq_count), 64'd1);
        chk("clamp_deqpc", deq_pc_flat, 64'h000C_0000_0000_0000);
        fall(); #1;
        chk("drain_cnt0", 64'(deq_count), 64'd0);
        chk("drain_halted", 64'(halted), 64'd1);
        fall(); #1;
        chk("drain_no_underflow", 64'(deq_count), 64'd0);
        chk("drain_nf", 64'(num_fetch), 64'd0);

        // Build 10 entries ending in a HALT, then redirect with deq_take=2
        fall(); redirect_valid = 1'b1; redirect_pc = 16'h0040; deq_take = 3'd0;
        halt_pc = 16'h0052; #1;
        chk("redir_halted_nf", 64'(num_fetch), 64'd0);
        fall(); redirect_valid = 1'b0; #1;
        chk("unhalt_flag", 64'(halted), 64'd0);
        chk("unhalt_nf", 64'(num_fetch), 64'd4);
        fall(); #1;
        chk("q10_nf_b", 64'(num_fetch), 64'd4);
        fall(); #1;
        chk("q10_pcgrp", pc_to_icache_flat, grp(16'h0050));
        chk("q10_nf_c", 64'(num_fetch), 64'd2);
        fall(); redirect_valid = 1'b1; redirect_pc = 16'h0100; deq_take = 3'd2; #1;
        chk("flush_pre_halted", 64'(halted), 64'd1);
        chk("flush_pre_cnt", 64'(deq_count), 64'd4);
        chk("flush_pre_deqpc", deq_pc_flat, grp(16'h0040));
        fall(); redirect_valid = 1'b0; deq_take = 3'd0; halt_en = 1'b0; #1;
        chk("flush_cnt", 64'(deq_count), 64'd0);
        chk("flush_pcgrp", pc_to_icache_flat, grp(16'h0100));
        chk("flush_halted", 64'(halted), 64'd0);
        chk("flush_nf", 64'(num_fetch), 64'd4);
        fall(); #1;
        chk("post_flush_cnt", 64'(deq_count), 64'd4);
        chk("post_flush_deqpc", deq_pc_flat, grp(16'h0100));

        // Redirect near the top of the PC space: 16-bit wrap
        fall(); redirect_valid = 1'b1; redirect_pc = 16'hFFFC; #1;
        chk("wrap_redir_nf", 64'(num_fetch), 64'd0);
        fall(); redirect_valid = 1'b0; #1;
        chk("wrap_pcgrp", pc_to_icache_flat, 64'hFFFC_FFFE_0000_0002);
        chk("wrap_cnt0", 64'(deq_count), 64'd0);
        fall(); #1;
        chk("wrap_deqpc", deq_pc_flat, 64'hFFFC_FFFE_0000_0002);
        chk("wrap_deqinstr", deq_instr_flat, 64'h0FFC_0FFE_0000_0002);
        chk("wrap_next_pcgrp", pc_to_icache_flat, grp(16'h0004));

        // Reset mid-operation discards everything
        fall(); rst_n = 1'b0; #1;
        chk("midrst_cnt", 64'(deq_count), 64'd0);
        chk("midrst_pcgrp", pc_to_icache_flat, grp(16'h0000));
        chk("midrst_nf", 64'(num_fetch), 64'd0);
        fall(); rst_n = 1'b1; #1;
        chk("midrst_rel_nf", 64'(num_fetch), 64'd4);
        chk("midrst_rel_cnt", 64'(deq_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
